// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants, IF/ID record type and the fetch address
//                range helper for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Bubble encoding: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_BYTES = 8192;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } if_id_t;

    // True when the byte address falls inside a ROM of the given size.
    // Alignment is checked separately by the caller.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] bytes);
        return (addr < bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundle of the ROM bus, pipeline control and IF/ID outputs
//                of the fetch stage. master = fetch stage side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instr;
    logic        o_id_fault;
    logic [31:0] o_fetch_count;

    modport master (
        output o_imem_addr,
        input  i_imem_rdata,
        input  i_stall,
        input  i_redirect_valid,
        input  i_redirect_pc,
        output o_id_valid,
        output o_id_pc,
        output o_id_instr,
        output o_id_fault,
        output o_fetch_count
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_rdata,
        output i_stall,
        output i_redirect_valid,
        output i_redirect_pc,
        input  o_id_valid,
        input  o_id_pc,
        input  o_id_instr,
        input  o_id_fault,
        input  o_fetch_count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with load / hold / bubble control.
//                A bubble clears valid, instr and fault but keeps the pc
//                field so the last delivered PC stays visible downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
(
    input  wire logic   i_clk,
    input  wire logic   i_reset,
    input  wire logic   i_load,
    input  wire logic   i_bubble,
    input  wire if_id_t i_data,
    output if_id_t      o_data
);

    if_id_t data_q;
    if_id_t data_d;

    // Select next contents: bubble beats load, otherwise hold
    always_comb begin
        data_d = data_q;
        if (i_bubble) begin
            data_d.valid = 1'b0;
            data_d.instr = NOP_INSTR;
            data_d.fault = 1'b0;
        end else if (i_load) begin
            data_d = i_data;
        end
    end

    // Register with synchronous reset to an all-bubble record at pc 0
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, addresses the ROM
//                combinationally from the PC register, and captures the
//                returned word (or a faulting NOP) into IF/ID. Handles
//                stall, redirect and out-of-range / misaligned fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  wire logic     i_clk,
    input  wire logic     i_reset,
    fetch_stage_if.master bus
);

    localparam logic [31:0] C_IMEM_BYTES = IMEM_BYTES[31:0];

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic        w_load;
    logic        w_bubble;
    logic        w_fetch_ok;
    if_id_t      w_fetch;
    if_id_t      w_if_id;

    // Word at pc_q is usable only if it lies inside the ROM and is aligned;
    // anything else becomes a faulting NOP so decode never sees ROM garbage.
    always_comb begin
        w_fetch_ok    = in_range(pc_q, C_IMEM_BYTES) && (pc_q[1:0] == 2'b00);
        w_fetch.valid = 1'b1;
        w_fetch.pc    = pc_q;
        w_fetch.instr = w_fetch_ok ? bus.i_imem_rdata : NOP_INSTR;
        w_fetch.fault = ~w_fetch_ok;
    end

    // PC / counter next state and IF/ID control: redirect > stall > advance
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        w_load        = 1'b0;
        w_bubble      = 1'b0;
        if (bus.i_redirect_valid) begin
            pc_d     = bus.i_redirect_pc;
            w_bubble = 1'b1;
        end else if (!bus.i_stall) begin
            pc_d          = pc_q + 32'd4;
            fetch_count_d = fetch_count_q + 32'd1;
            w_load        = 1'b1;
        end
    end

    // PC and delivered-instruction counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_data   (w_fetch),
        .o_data   (w_if_id)
    );

    assign bus.o_imem_addr   = pc_q;
    assign bus.o_id_valid    = w_if_id.valid;
    assign bus.o_id_pc       = w_if_id.pc;
    assign bus.o_id_instr    = w_if_id.instr;
    assign bus.o_id_fault    = w_if_id.fault;
    assign bus.o_fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: a directed vector
//                table followed by a randomised scoreboard run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic i_clk = 1'b0;
    logic i_reset;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bif ();

    fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (8192)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bif.master)
    );

    always #5 i_clk = ~i_clk;

    // ROM model: fixed program at words 0..3, address-tagged words elsewhere
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr[12:2])
            11'd0:   return 32'h0050_0093;
            11'd1:   return 32'h0010_0113;
            11'd2:   return 32'h0020_81B3;
            11'd3:   return 32'h0000_0013;
            default: return 32'hA500_0000 | {19'h0, addr[12:0]};
        endcase
    endfunction

    assign bif.i_imem_rdata = rom_word(bif.o_imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic e_fault,
                       input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_fault = e_fault; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    // Global safety net
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_cnt;
        logic        adv;
        logic        redir;
        logic        bad;
        exp_t        e;
        exp_t        got;

        i_reset              = 1'b1;
        bif.i_stall          = 1'b0;
        bif.i_redirect_valid = 1'b0;
        bif.i_redirect_pc    = 32'h0;

        //   rst stall redir rpc           addr          v  id_pc         instr         f  cnt
        // reset and straight-line run
        add(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        C_NOP,        0, 0);
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h00500093, 0, 1);
        add(0, 0, 0, 32'h0,        32'h8,        1, 32'h4,        32'h00100113, 0, 2);
        add(0, 0, 0, 32'h0,        32'hC,        1, 32'h8,        32'h002081B3, 0, 3);
        add(0, 0, 0, 32'h0,        32'h10,       1, 32'hC,        32'h00000013, 0, 4);
        // stall three cycles at pc 8, then release
        add(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        C_NOP,        0, 0);
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h00500093, 0, 1);
        add(0, 0, 0, 32'h0,        32'h8,        1, 32'h4,        32'h00100113, 0, 2);
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h00100113, 0, 2);
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h00100113, 0, 2);
        add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h00100113, 0, 2);
        add(0, 0, 0, 32'h0,        32'hC,        1, 32'h8,        32'h002081B3, 0, 3);
        add(0, 0, 0, 32'h0,        32'h10,       1, 32'hC,        32'h00000013, 0, 4);
        // redirect together with stall
        add(0, 1, 1, 32'h40,       32'h40,       0, 32'hC,        C_NOP,        0, 4);
        add(0, 0, 0, 32'h0,        32'h44,       1, 32'h40,       32'hA5000040, 0, 5);
        // redirect to first out-of-range byte
        add(0, 0, 1, 32'h2000,     32'h2000,     0, 32'h40,       C_NOP,        0, 5);
        add(0, 0, 0, 32'h0,        32'h2004,     1, 32'h2000,     C_NOP,        1, 6);
        // last in-range word
        add(0, 0, 1, 32'h1FFC,     32'h1FFC,     0, 32'h2000,     C_NOP,        0, 6);
        add(0, 0, 0, 32'h0,        32'h2000,     1, 32'h1FFC,     32'hA5001FFC, 0, 7);
        // misaligned target
        add(0, 0, 1, 32'h6,        32'h6,        0, 32'h1FFC,     C_NOP,        0, 7);
        add(0, 0, 0, 32'h0,        32'hA,        1, 32'h6,        C_NOP,        1, 8);
        // back-to-back redirects, then reset during a redirect
        add(0, 0, 1, 32'h100,      32'h100,      0, 32'h6,        C_NOP,        0, 8);
        add(0, 0, 1, 32'h1C,       32'h1C,       0, 32'h6,        C_NOP,        0, 8);
        add(1, 0, 1, 32'h80,       32'h0,        0, 32'h0,        C_NOP,        0, 0);
        // PC wrap at top of address space
        add(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0,        C_NOP,        0, 0);
        add(0, 0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, C_NOP,        1, 1);
        add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h00500093, 0, 2);

        foreach (vecs[i]) begin
            @(negedge i_clk);
            i_reset              = vecs[i].rst;
            bif.i_stall          = vecs[i].stall;
            bif.i_redirect_valid = vecs[i].redir;
            bif.i_redirect_pc    = vecs[i].rpc;
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d imem_addr", i), bif.o_imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d id_valid", i), {31'h0, bif.o_id_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d id_pc", i), bif.o_id_pc, vecs[i].e_pc);
            chk($sformatf("v%0d id_instr", i), bif.o_id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d id_fault", i), {31'h0, bif.o_id_fault}, {31'h0, vecs[i].e_fault});
            chk($sformatf("v%0d fetch_count", i), bif.o_fetch_count, vecs[i].e_cnt);
        end

        // Randomised run: expected deliveries queued when an advance is driven,
        // popped when the DUT presents the new IF/ID contents.
        @(negedge i_clk);
        i_reset              = 1'b1;
        bif.i_stall          = 1'b0;
        bif.i_redirect_valid = 1'b0;
        @(posedge i_clk);
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clk);
            i_reset              = 1'b0;
            redir                = ($urandom_range(0, 7) == 0);
            bif.i_stall          = ($urandom_range(0, 3) == 0);
            bif.i_redirect_valid = redir;
            case ($urandom_range(0, 3))
                0:       bif.i_redirect_pc = 32'h1FE0 + {$urandom_range(0, 15), 2'b00};
                1:       bif.i_redirect_pc = {$urandom_range(0, 2047), 2'b00};
                2:       bif.i_redirect_pc = $urandom_range(0, 255);
                default: bif.i_redirect_pc = {$urandom_range(0, 63), 2'b00};
            endcase
            adv = !redir && !bif.i_stall;
            if (redir) begin
                m_pc = bif.i_redirect_pc;
            end else if (adv) begin
                bad     = (m_pc >= 32'd8192) || (m_pc[1:0] != 2'b00);
                e.pc    = m_pc;
                e.fault = bad;
                e.instr = bad ? C_NOP : rom_word(m_pc);
                sb.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
            @(posedge i_clk);
            #1;
            chk($sformatf("r%0d imem_addr", c), bif.o_imem_addr, m_pc);
            if (adv) begin
                chk($sformatf("r%0d id_valid", c), {31'h0, bif.o_id_valid}, 32'h1);
                got.pc    = bif.o_id_pc;
                got.instr = bif.o_id_instr;
                got.fault = bif.o_id_fault;
                e = sb.pop_front();
                chk($sformatf("r%0d id_pc", c), got.pc, e.pc);
                chk($sformatf("r%0d id_instr", c), got.instr, e.instr);
                chk($sformatf("r%0d id_fault", c), {31'h0, got.fault}, {31'h0, e.fault});
            end else if (redir) begin
                chk($sformatf("r%0d bubble_valid", c), {31'h0, bif.o_id_valid}, 32'h0);
                chk($sformatf("r%0d bubble_instr", c), bif.o_id_instr, C_NOP);
            end
        end
        chk("rand fetch_count", bif.o_fetch_count, m_cnt);
        chk("rand scoreboard_left", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the 8 KiB instruction ROM.
- Owns the PC register and drives the ROM word address.
- Captures the combinational ROM read data into an IF/ID pipeline register for decode.
- Handles stall, redirect (branch/jump) and out-of-range fetch, inserting NOP bubbles (0x00000013) where required.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_BYTES, 8192, instruction ROM size in bytes; fetches at or above this are out-of-range
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
o_imem_addr  out  32  byte address to instruction ROM (= pc_q)
i_imem_rdata  in  32  ROM read data, combinational from o_imem_addr, same cycle
i_stall  in  1  hold PC and IF/ID (decode not accepting)
i_redirect_valid  in  1  redirect fetch to i_redirect_pc
i_redirect_pc  in  32  redirect target byte address
o_id_valid  out  1  IF/ID holds a real instruction
o_id_pc  out  32  PC of instruction in IF/ID
o_id_instr  out  32  instruction in IF/ID
o_id_fault  out  1  IF/ID instruction came from an out-of-range or misaligned fetch
o_fetch_count  out  32  count of valid instructions delivered to IF/ID

Behaviour:
- Reset (i_reset=1 at edge):
  - pc_q=RESET_PC; o_id_valid=0; o_id_pc=0; o_id_instr=NOP_INSTR; o_id_fault=0; o_fetch_count=0.
  - Reset overrides every other input.
- o_imem_addr = pc_q, combinational, no latency. Instruction for pc_q is sampled in the same cycle and appears on o_id_* one edge later.
- Per-edge priority: reset > redirect > stall > advance.
- Advance (no stall, no redirect):
  - pc_q <= pc_q + 4, 32-bit modulo; wrap from 0xFFFF_FFFC to 0 is legal.
  - IF/ID <= {valid=1, pc=pc_q, instr=fetched, fault=f}.
  - o_fetch_count += 1, wraps modulo 2^32.
- Fetch data and fault for the current pc_q:
  - In range (pc_q < IMEM_BYTES, pc_q[1:0]==0): fetched=i_imem_rdata, f=0.
  - Out-of-range or pc_q[1:0]!=0: fetched=NOP_INSTR, f=1.
- Redirect (i_redirect_valid=1):
  - pc_q <= i_redirect_pc, unmodified; misalignment is flagged on the next fetch via f.
  - IF/ID <= bubble: valid=0, instr=NOP_INSTR, fault=0; pc field holds its previous value.
  - The wrong-path instruction at the old pc_q is discarded and the counter is not incremented.
  - Redirect wins over a simultaneous stall.
- Stall (i_stall=1, no redirect): pc_q, IF/ID and counter all hold. o_imem_addr stays stable.
- Stall held N cycles then released: the next edge captures the instruction at the held pc_q exactly once. No skip, no duplicate.
- Back-to-back redirects: the last one wins each cycle. Only a non-redirect, non-stall edge delivers a valid instruction.
- Reset asserted mid-stall or mid-redirect: the reset values above apply on that edge.
- No combinational path from i_stall or i_redirect_* to o_imem_addr. All outputs are registered except o_imem_addr, which is a direct copy of pc_q.

Decomposition:
- Package fetch_pkg:
  - localparam NOP_INSTR.
  - default RESET_PC.
  - typedef struct packed if_id_t {valid, pc[31:0], instr[31:0], fault}.
  - function in_range(addr, bytes).
- One sub-module, if_id_reg: holds if_id_t with load/hold/bubble controls and synchronous reset to the bubble value.
- PC next-state logic stays in fetch_stage.

Test Plan:
1. Reset then run 4 cycles, ROM words 0..3 = 0x00500093,0x00100113,0x002081B3,0x00000013
   -> o_id_pc 0,4,8,12 with matching instrs, valid=1 from cycle 1, o_fetch_count=4.
2. Stall asserted 3 cycles while pc_q=8, then released
   -> o_imem_addr=8 held, IF/ID frozen at pc 4 during stall; next edge delivers pc 8 exactly once; count increments once.
3. Redirect to 0x40 together with stall at pc_q=0x10
   -> next cycle pc_q=0x40, o_id_valid=0, o_id_instr=0x00000013; following edge delivers pc 0x40, valid=1.
4. Redirect to 0x2000 (=IMEM_BYTES)
   -> after one bubble, IF/ID {pc=0x2000, instr=0x00000013, fault=1, valid=1}; pc_q advances to 0x2004.
5. Redirect to 0x0000_0006 (misaligned)
   -> IF/ID {pc=6, instr=NOP, fault=1}; next pc_q=0xA.
6. Reset asserted while pc_q=0x1C and i_redirect_valid=1
   -> pc_q=RESET_PC, o_id_valid=0, o_fetch_count=0 on that edge; redirect is ignored.
